// File: rtl/nand_gate_unit.sv
// Bit-parallel AND / NOR / NOT unit built only from 2-input NAND gates,
// with combinational results and a valid-qualified registered copy.
module nand_gate_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] and_c,
    output logic [WIDTH-1:0] nor_c,
    output logic [WIDTH-1:0] not_c,
    output logic             out_valid,
    output logic [WIDTH-1:0] and_q,
    output logic [WIDTH-1:0] nor_q,
    output logic [WIDTH-1:0] not_q
);

    // The single primitive every datapath gate is derived from.
    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_nor;
    logic [WIDTH-1:0] w_not;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_and_q;
    logic [WIDTH-1:0] r_nor_q;
    logic [WIDTH-1:0] r_not_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_n;
        logic w_na;
        logic w_nb;
        logic w_or;

        assign w_n  = nand2(a[i], b[i]);
        assign w_na = nand2(a[i], a[i]);
        assign w_nb = nand2(b[i], b[i]);
        assign w_or = nand2(w_na, w_nb);

        assign w_not[i] = nand2(a[i], a[i]);
        assign w_and[i] = nand2(w_n, w_n);
        assign w_nor[i] = nand2(w_or, w_or);
    end

    assign and_c = w_and;
    assign nor_c = w_nor;
    assign not_c = w_not;

    // Capture results on a valid input; results hold while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_and_q     <= {WIDTH{1'b0}};
            r_nor_q     <= {WIDTH{1'b0}};
            r_not_q     <= {WIDTH{1'b0}};
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_and_q <= w_and;
                r_nor_q <= w_nor;
                r_not_q <= w_not;
            end else begin
                r_and_q <= r_and_q;
                r_nor_q <= r_nor_q;
                r_not_q <= r_not_q;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign and_q     = r_and_q;
    assign nor_q     = r_nor_q;
    assign not_q     = r_not_q;

endmodule

// File: tb/tb_nand_gate_unit.sv
// Directed self-checking bench for nand_gate_unit at WIDTH=1 and WIDTH=8.
module tb_nand_gate_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv1, iv8;
    logic [0:0] a1, b1;
    logic [7:0] a8, b8;

    logic [0:0] and_c1, nor_c1, not_c1, and_q1, nor_q1, not_q1;
    logic       ov1;
    logic [7:0] and_c8, nor_c8, not_c8, and_q8, nor_q8, not_q8;
    logic       ov8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nand_gate_unit #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1),
        .and_c(and_c1), .nor_c(nor_c1), .not_c(not_c1),
        .out_valid(ov1), .and_q(and_q1), .nor_q(nor_q1), .not_q(not_q1)
    );

    nand_gate_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8),
        .and_c(and_c8), .nor_c(nor_c8), .not_c(not_c8),
        .out_valid(ov8), .and_q(and_q8), .nor_q(nor_q8), .not_q(not_q8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Truth table rows: {a,b} -> {and,nor,not}
    logic [1:0] tt_in  [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [2:0] tt_out [4] = '{3'b011, 3'b000, 3'b001, 3'b100};

    // Streaming vectors: a, b, and, nor, not
    logic [7:0] st [3][5] = '{
        '{8'hF0, 8'h3C, 8'h30, 8'h03, 8'h0F},
        '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF},
        '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00}
    };

    // Idle-phase vectors: a, b, and, nor, not
    logic [7:0] hv [5][5] = '{
        '{8'h0F, 8'h33, 8'h03, 8'hC0, 8'hF0},
        '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h5A},
        '{8'h3C, 8'hC3, 8'h00, 8'h00, 8'hC3},
        '{8'h81, 8'h18, 8'h00, 8'h66, 8'h7E},
        '{8'hFE, 8'h7F, 8'h7E, 8'h00, 8'h01}
    };

    initial begin
        rst_n = 1'b0;
        iv1 = 1'b0; iv8 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        #3;
        chk("rst_ov1",  {63'd0, ov1}, 64'd0);
        chk("rst_and1", {63'd0, and_q1}, 64'd0);
        chk("rst_nor1", {63'd0, nor_q1}, 64'd0);
        chk("rst_not1", {63'd0, not_q1}, 64'd0);
        chk("rst_ov8",  {63'd0, ov8}, 64'd0);
        chk("rst_q8",   {40'd0, and_q8, nor_q8, not_q8}, 64'd0);

        // WIDTH=1 combinational truth table, live while in reset
        for (int i = 0; i < 4; i++) begin
            a1 = tt_in[i][1];
            b1 = tt_in[i][0];
            #2;
            chk("tt_comb", {61'd0, and_c1, nor_c1, not_c1}, {61'd0, tt_out[i]});
        end

        // in_valid coincident with reset across an edge is discarded
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        chk("rstiv_ov8",  {63'd0, ov8}, 64'd0);
        chk("rstiv_and8", {56'd0, and_q8}, 64'd0);
        chk("rstiv_not8", {56'd0, not_q8}, 64'd0);

        @(negedge clk);
        iv8 = 1'b0;
        rst_n = 1'b1;

        // WIDTH=1 single capture then idle
        @(negedge clk);
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        @(posedge clk); #1;
        chk("cap_ov1",  {63'd0, ov1}, 64'd1);
        chk("cap_and1", {63'd0, and_q1}, 64'd1);
        chk("cap_nor1", {63'd0, nor_q1}, 64'd0);
        chk("cap_not1", {63'd0, not_q1}, 64'd0);
        @(negedge clk);
        iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        @(posedge clk); #1;
        chk("hold_ov1",  {63'd0, ov1}, 64'd0);
        chk("hold_q1",   {61'd0, and_q1, nor_q1, not_q1}, {61'd0, 3'b100});

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ov1", {63'd0, ov1}, 64'd0);
        chk("arst_q1",  {61'd0, and_q1, nor_q1, not_q1}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=8 back-to-back streaming
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            iv8 = 1'b1; a8 = st[i][0]; b8 = st[i][1];
            #1;
            chk("st_comb", {40'd0, and_c8, nor_c8, not_c8}, {40'd0, st[i][2], st[i][3], st[i][4]});
            @(posedge clk); #1;
            chk("st_ov8", {63'd0, ov8}, 64'd1);
            chk("st_q8",  {40'd0, and_q8, nor_q8, not_q8}, {40'd0, st[i][2], st[i][3], st[i][4]});
        end
        @(negedge clk);
        iv8 = 1'b0;
        @(posedge clk); #1;
        chk("st_end_ov8", {63'd0, ov8}, 64'd0);

        // Capture 0x55/0xAA then idle with changing inputs
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'h55; b8 = 8'hAA;
        @(posedge clk); #1;
        chk("hc_q8", {40'd0, and_q8, nor_q8, not_q8}, {40'd0, 8'h00, 8'h00, 8'hAA});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            iv8 = 1'b0; a8 = hv[i][0]; b8 = hv[i][1];
            @(posedge clk); #1;
            chk("idle_ov8",  {63'd0, ov8}, 64'd0);
            chk("idle_q8",   {40'd0, and_q8, nor_q8, not_q8}, {40'd0, 8'h00, 8'h00, 8'hAA});
            chk("idle_comb", {40'd0, and_c8, nor_c8, not_c8}, {40'd0, hv[i][2], hv[i][3], hv[i][4]});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nand_gate_unit.md
Name: nand_gate_unit

Overview:
- Bit-parallel logic unit that produces AND, NOR and NOT of its operands.
- All logic is built exclusively from 2-input NAND gates.
- Provides combinational outputs plus a registered, valid-qualified copy of each result.
- Serves as the NAND-derived gate library core for the design, replacing separate and/nor/not cells.

Parameters:
WIDTH, 1, bit width of operands a, b and of every result bus (legal range 1..64)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  qualifies a/b for capture on the next rising clk edge
a  input  WIDTH  operand A (also the NOT operand)
b  input  WIDTH  operand B
and_c  output  WIDTH  combinational a AND b
nor_c  output  WIDTH  combinational NOT(a OR b)
not_c  output  WIDTH  combinational NOT a
out_valid  output  1  registered; high for one cycle per captured input
and_q  output  WIDTH  registered a AND b
nor_q  output  WIDTH  registered NOT(a OR b)
not_q  output  WIDTH  registered NOT a

Behaviour:
- Gate construction is per bit i, NAND only; no other logic operators in the datapath:
  - not_c[i] = nand(a[i], a[i]): 1 NAND.
  - and_c[i] = nand(n, n) where n = nand(a[i], b[i]): 2 NANDs.
  - nor_c[i]: na = nand(a[i], a[i]), nb = nand(b[i], b[i]), o = nand(na, nb), nor_c[i] = nand(o, o): 4 NANDs.
  - Total is 7 NANDs per bit. Generate loop over WIDTH.
- Truth table per bit (a b -> and nor not):
  - 0 0 -> 0 1 1
  - 1 0 -> 0 0 0
  - 0 1 -> 0 0 1
  - 1 1 -> 1 0 0
- Combinational outputs:
  - Follow a/b with zero clock latency.
  - Independent of clk, rst_n and in_valid.
- Registered path:
  - On a rising clk edge with in_valid=1: and_q/nor_q/not_q load and_c/nor_c/not_c, and out_valid <= 1.
  - On a rising clk edge with in_valid=0: result registers hold their previous value, and out_valid <= 0.
  - Latency: exactly 1 cycle from the sampled in_valid to out_valid.
  - Back-to-back in_valid every cycle is supported (full throughput). No backpressure.
- Reset:
  - rst_n low forces, immediately and asynchronously: out_valid=0, and_q=0, nor_q=0, not_q=0, all bits.
  - These values hold while rst_n is low; combinational outputs stay live.
  - Reset deassertion is synchronous to clk at the integration level.
  - The first capture occurs on the first rising edge with rst_n=1 and in_valid=1.
- Reset mid-operation: an in_valid pulse coincident with reset assertion is discarded; out_valid does not pulse for it.
- X/Z on a or b propagates per standard NAND semantics; no masking.
- Width rules:
  - All result buses equal WIDTH. No carries; bits are fully independent.
  - WIDTH=1 must reproduce the truth table above exactly.

Test Plan:
- WIDTH=1 comb truth table: apply a/b = 00, 10, 01, 11 for 10 time units each -> (and_c, nor_c, not_c) = 011, 000, 001, 100 respectively.
- Registered capture: reset released, in_valid=1 with a=1, b=1 for one cycle, then in_valid=0 -> next cycle out_valid=1, and_q=1, nor_q=0, not_q=0; the following cycle out_valid=0 and results hold 1/0/0.
- Async reset: with and_q=1 held, drive rst_n=0 between clock edges -> and_q, nor_q, not_q and out_valid go to 0 immediately, no clock edge required.
- Streaming, WIDTH=8: in_valid high for 3 cycles with (a,b) = (0xF0,0x3C), (0x00,0x00), (0xFF,0xFF) -> out_valid high 3 consecutive cycles:
  - and_q = 0x30, 0x00, 0xFF
  - nor_q = 0x03, 0xFF, 0x00
  - not_q = 0x0F, 0xFF, 0x00
- Hold on idle: capture a=0x55, b=0xAA (WIDTH=8), then change a/b with in_valid=0 for 5 cycles -> and_q=0x00, nor_q=0x00, not_q=0xAA unchanged; comb outputs track the new inputs.
- Reset coincident with in_valid: rst_n=0 while in_valid=1 across a clock edge -> out_valid remains 0 and registers remain 0.
